// File: rtl/rename_unit.sv
// rename_unit: two-wide register rename stage with a register alias table
// and a circular free list of physical registers; results registered one cycle later.
module rename_unit #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int FREE_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  in1_opcode,
    input  logic [4:0]  in1_rs1,
    input  logic [4:0]  in1_rs2,
    input  logic [4:0]  in1_rd,
    input  logic [31:0] in1_imm,
    input  logic [6:0]  in1_funct7,
    input  logic [2:0]  in1_funct3,
    input  logic [6:0]  in2_opcode,
    input  logic [4:0]  in2_rs1,
    input  logic [4:0]  in2_rs2,
    input  logic [4:0]  in2_rd,
    input  logic [31:0] in2_imm,
    input  logic [6:0]  in2_funct7,
    input  logic [2:0]  in2_funct3,
    input  logic [5:0]  free_reg1,
    input  logic [5:0]  free_reg2,
    output logic        stall,
    output logic [6:0]  instr1_opcode,
    output logic [31:0] instr1_imm,
    output logic [6:0]  instr1_funct7,
    output logic [2:0]  instr1_funct3,
    output logic [5:0]  instr1_p_rs1,
    output logic [5:0]  instr1_p_rs2,
    output logic [5:0]  instr1_p_rd,
    output logic [5:0]  instr1_p_old_rd,
    output logic [6:0]  instr2_opcode,
    output logic [31:0] instr2_imm,
    output logic [6:0]  instr2_funct7,
    output logic [2:0]  instr2_funct3,
    output logic [5:0]  instr2_p_rs1,
    output logic [5:0]  instr2_p_rs2,
    output logic [5:0]  instr2_p_rd,
    output logic [5:0]  instr2_p_old_rd
);
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [5:0] FULL     = 6'(FREE_DEPTH);

    logic [5:0] rat_q [ARCH_REGS];
    logic [5:0] fl_q [FREE_DEPTH];
    logic [4:0] head_q, head_d, tail_q, tail_d;
    logic [5:0] count_q, count_d;

    logic       w1, w2, v1, v2, ok1, ok2, drop;
    logic [1:0] need, pops;
    logic [5:0] occ, occ1;
    logic [5:0] alloc1, alloc2;
    logic [5:0] p1_rs1, p1_rs2, p1_rd, p1_old;
    logic [5:0] p2_rs1, p2_rs2, p2_rd, p2_old;

    function automatic logic is_writer(input logic [6:0] op, input logic [4:0] rd);
        return rd != 5'd0 && (op == OP_RTYPE || op == OP_ITYPE || op == OP_LW);
    endfunction

    assign w1    = is_writer(in1_opcode, in1_rd);
    assign w2    = is_writer(in2_opcode, in2_rd);
    assign need  = {1'b0, w1} + {1'b0, w2};
    assign stall = {4'd0, need} > count_q;
    assign pops  = stall ? 2'd0 : need;

    // Slot 2 takes the entry after slot 1's, or the head when slot 1 does not write.
    assign alloc1 = fl_q[head_q];
    assign alloc2 = fl_q[head_q + {4'd0, w1}];

    assign p1_rs1 = rat_q[in1_rs1];
    assign p1_rs2 = rat_q[in1_rs2];
    assign p1_rd  = w1 ? alloc1 : 6'd0;
    assign p1_old = w1 ? rat_q[in1_rd] : 6'd0;

    // Slot 1's new mapping is not in the RAT yet, so slot 2 reads it through a bypass.
    assign p2_rs1 = (w1 && in2_rs1 == in1_rd) ? alloc1 : rat_q[in2_rs1];
    assign p2_rs2 = (w1 && in2_rs2 == in1_rd) ? alloc1 : rat_q[in2_rs2];
    assign p2_rd  = w2 ? alloc2 : 6'd0;
    assign p2_old = !w2 ? 6'd0 : (w1 && in2_rd == in1_rd) ? alloc1 : rat_q[in2_rd];

    assign v1   = free_reg1 != 6'd0;
    assign v2   = free_reg2 != 6'd0;
    assign occ  = count_q - {4'd0, pops};
    assign ok1  = v1 && occ < FULL;
    assign occ1 = occ + {5'd0, ok1};
    assign ok2  = v2 && occ1 < FULL;
    assign drop = (v1 && !ok1) || (v2 && !ok2);

    assign head_d  = head_q + {3'd0, pops};
    assign tail_d  = tail_q + {4'd0, ok1} + {4'd0, ok2};
    assign count_d = occ1 + {5'd0, ok2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= 6'(i);
            for (int i = 0; i < FREE_DEPTH; i++) fl_q[i] <= 6'(PHYS_REGS - FREE_DEPTH + i);
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= FULL;
            instr1_opcode   <= '0;
            instr1_imm      <= '0;
            instr1_funct7   <= '0;
            instr1_funct3   <= '0;
            instr1_p_rs1    <= '0;
            instr1_p_rs2    <= '0;
            instr1_p_rd     <= '0;
            instr1_p_old_rd <= '0;
            instr2_opcode   <= '0;
            instr2_imm      <= '0;
            instr2_funct7   <= '0;
            instr2_funct3   <= '0;
            instr2_p_rs1    <= '0;
            instr2_p_rs2    <= '0;
            instr2_p_rd     <= '0;
            instr2_p_old_rd <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!stall && w1) rat_q[in1_rd] <= alloc1;
            if (!stall && w2) rat_q[in2_rd] <= alloc2;
            if (ok1) fl_q[tail_q] <= free_reg1;
            if (ok2) fl_q[tail_q + {4'd0, ok1}] <= free_reg2;
            instr1_opcode   <= stall ? '0 : in1_opcode;
            instr1_imm      <= stall ? '0 : in1_imm;
            instr1_funct7   <= stall ? '0 : in1_funct7;
            instr1_funct3   <= stall ? '0 : in1_funct3;
            instr1_p_rs1    <= stall ? '0 : p1_rs1;
            instr1_p_rs2    <= stall ? '0 : p1_rs2;
            instr1_p_rd     <= stall ? '0 : p1_rd;
            instr1_p_old_rd <= stall ? '0 : p1_old;
            instr2_opcode   <= stall ? '0 : in2_opcode;
            instr2_imm      <= stall ? '0 : in2_imm;
            instr2_funct7   <= stall ? '0 : in2_funct7;
            instr2_funct3   <= stall ? '0 : in2_funct3;
            instr2_p_rs1    <= stall ? '0 : p2_rs1;
            instr2_p_rs2    <= stall ? '0 : p2_rs2;
            instr2_p_rd     <= stall ? '0 : p2_rd;
            instr2_p_old_rd <= stall ? '0 : p2_old;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && drop) $error("rename_unit: push to full free list dropped");
    end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed vectors with hand-computed renames for rename_unit.
module tb_rename_unit;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] SW = 7'b0100011;

    logic        clk, rst_n;
    logic [6:0]  in1_opcode, in2_opcode, in1_funct7, in2_funct7;
    logic [4:0]  in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd;
    logic [31:0] in1_imm, in2_imm;
    logic [2:0]  in1_funct3, in2_funct3;
    logic [5:0]  free_reg1, free_reg2;
    logic        stall;
    logic [6:0]  instr1_opcode, instr2_opcode, instr1_funct7, instr2_funct7;
    logic [31:0] instr1_imm, instr2_imm;
    logic [2:0]  instr1_funct3, instr2_funct3;
    logic [5:0]  instr1_p_rs1, instr1_p_rs2, instr1_p_rd, instr1_p_old_rd;
    logic [5:0]  instr2_p_rs1, instr2_p_rs2, instr2_p_rd, instr2_p_old_rd;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_order [32];

    rename_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in1_opcode(in1_opcode), .in1_rs1(in1_rs1), .in1_rs2(in1_rs2), .in1_rd(in1_rd),
        .in1_imm(in1_imm), .in1_funct7(in1_funct7), .in1_funct3(in1_funct3),
        .in2_opcode(in2_opcode), .in2_rs1(in2_rs1), .in2_rs2(in2_rs2), .in2_rd(in2_rd),
        .in2_imm(in2_imm), .in2_funct7(in2_funct7), .in2_funct3(in2_funct3),
        .free_reg1(free_reg1), .free_reg2(free_reg2), .stall(stall),
        .instr1_opcode(instr1_opcode), .instr1_imm(instr1_imm), .instr1_funct7(instr1_funct7),
        .instr1_funct3(instr1_funct3), .instr1_p_rs1(instr1_p_rs1), .instr1_p_rs2(instr1_p_rs2),
        .instr1_p_rd(instr1_p_rd), .instr1_p_old_rd(instr1_p_old_rd),
        .instr2_opcode(instr2_opcode), .instr2_imm(instr2_imm), .instr2_funct7(instr2_funct7),
        .instr2_funct3(instr2_funct3), .instr2_p_rs1(instr2_p_rs1), .instr2_p_rs2(instr2_p_rs2),
        .instr2_p_rd(instr2_p_rd), .instr2_p_old_rd(instr2_p_old_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input int s, input logic [6:0] op,
                            input logic [5:0] r1, input logic [5:0] r2,
                            input logic [5:0] rd, input logic [5:0] old);
        chk({tag, ".op"},  32'(s == 1 ? instr1_opcode   : instr2_opcode),   32'(op));
        chk({tag, ".rs1"}, 32'(s == 1 ? instr1_p_rs1    : instr2_p_rs1),    32'(r1));
        chk({tag, ".rs2"}, 32'(s == 1 ? instr1_p_rs2    : instr2_p_rs2),    32'(r2));
        chk({tag, ".rd"},  32'(s == 1 ? instr1_p_rd     : instr2_p_rd),     32'(rd));
        chk({tag, ".old"}, 32'(s == 1 ? instr1_p_old_rd : instr2_p_old_rd), 32'(old));
    endtask

    task automatic set_pair(input logic [6:0] o1, input logic [4:0] a1, input logic [4:0] b1,
                            input logic [4:0] d1, input logic [6:0] o2, input logic [4:0] a2,
                            input logic [4:0] b2, input logic [4:0] d2);
        in1_opcode = o1; in1_rs1 = a1; in1_rs2 = b1; in1_rd = d1;
        in2_opcode = o2; in2_rs1 = a2; in2_rs2 = b2; in2_rd = d2;
        in1_imm = 32'hA5A5_0000 | 32'(d1); in1_funct7 = 7'h20; in1_funct3 = 3'd5;
        in2_imm = 32'h5A5A_0000 | 32'(d2); in2_funct7 = 7'h01; in2_funct3 = 3'd2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        set_pair(0, 0, 0, 0, 0, 0, 0, 0);
        free_reg1 = 0; free_reg2 = 0;
        rst_n = 1'b0;
        #2;
        chk({tag, ".stall"}, 32'(stall), 0);
        chk_slot({tag, ".s1"}, 1, 0, 0, 0, 0, 0);
        chk_slot({tag, ".s2"}, 2, 0, 0, 0, 0, 0);
        chk({tag, ".imm1"}, instr1_imm, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        do_reset("rst0");

        set_pair(RT, 1, 2, 5, 0, 0, 0, 0);
        #1 chk("t1.stall", 32'(stall), 0);
        tick();
        chk_slot("t1.s1", 1, RT, 1, 2, 32, 5);
        chk("t1.op2", 32'(instr2_opcode), 0);
        chk("t1.imm", instr1_imm, 32'hA5A5_0005);
        chk("t1.f7", 32'(instr1_funct7), 32'h20);
        chk("t1.f3", 32'(instr1_funct3), 5);

        do_reset("rst1");
        set_pair(IT, 3, 0, 3, RT, 3, 3, 3);
        tick();
        chk_slot("raw.s1", 1, IT, 3, 0, 32, 3);
        chk_slot("raw.s2", 2, RT, 32, 32, 33, 32);
        chk("raw.imm2", instr2_imm, 32'h5A5A_0003);
        set_pair(RT, 3, 0, 4, 0, 0, 0, 0);
        tick();
        chk_slot("rat3", 1, RT, 33, 0, 34, 4);

        set_pair(SW, 8, 7, 0, RT, 1, 1, 0);
        tick();
        chk_slot("sw.s1", 1, SW, 8, 7, 0, 0);
        chk_slot("sw.s2", 2, RT, 1, 1, 0, 0);
        set_pair(IT, 9, 0, 9, 0, 0, 0, 0);
        tick();
        chk_slot("after_sw", 1, IT, 9, 0, 35, 9);

        do_reset("rst2");
        for (int k = 0; k < 16; k++) begin
            set_pair(RT, 1, 2, 10, RT, 1, 2, 11);
            tick();
            chk($sformatf("ex%0d.rd1", k), 32'(instr1_p_rd), 32'(32 + 2 * k));
            chk($sformatf("ex%0d.rd2", k), 32'(instr2_p_rd), 32'(33 + 2 * k));
        end
        set_pair(IT, 10, 0, 12, 0, 0, 0, 0);
        free_reg1 = 5;
        #1 chk("ex.stall", 32'(stall), 1);
        tick();
        chk("ex.bubble", 32'(instr1_opcode), 0);
        free_reg1 = 0;
        #1 chk("ex.unstall", 32'(stall), 0);
        tick();
        chk_slot("ex.reuse", 1, IT, 62, 0, 5, 12);

        set_pair(0, 0, 0, 0, 0, 0, 0, 0);
        free_reg1 = 6;
        tick();
        set_pair(IT, 13, 0, 13, IT, 14, 0, 14);
        free_reg1 = 7; free_reg2 = 8;
        #1 chk("c1.stall", 32'(stall), 1);
        tick();
        chk("c1.op1", 32'(instr1_opcode), 0);
        chk("c1.op2", 32'(instr2_opcode), 0);
        free_reg1 = 0; free_reg2 = 0;
        #1 chk("c1.unstall", 32'(stall), 0);
        tick();
        chk_slot("c1.s1", 1, IT, 13, 0, 6, 13);
        chk_slot("c1.s2", 2, IT, 14, 0, 7, 14);
        set_pair(RT, 0, 0, 15, 0, 0, 0, 0);
        tick();
        chk("c1.last", 32'(instr1_p_rd), 8);
        #1 chk("c1.empty", 32'(stall), 1);

        do_reset("rst3");
        for (int k = 0; k < 16; k++) begin
            set_pair(RT, 0, 0, 1, RT, 0, 0, 2);
            tick();
        end
        set_pair(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) exp_order[i] = (i < 24) ? 6'(40 + i) : 6'(i - 23);
        for (int k = 0; k < 16; k++) begin
            free_reg1 = exp_order[2 * k];
            free_reg2 = exp_order[2 * k + 1];
            tick();
        end
        free_reg1 = 0; free_reg2 = 0;
        for (int k = 0; k < 16; k++) begin
            set_pair(RT, 0, 0, 3, IT, 0, 0, 4);
            tick();
            chk($sformatf("wr%0d.rd1", k), 32'(instr1_p_rd), 32'(exp_order[2 * k]));
            chk($sformatf("wr%0d.rd2", k), 32'(instr2_p_rd), 32'(exp_order[2 * k + 1]));
        end
        set_pair(RT, 0, 0, 5, 0, 0, 0, 0);
        #1 chk("wr.empty", 32'(stall), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
# rename_unit

Two-wide register rename stage between instruction decode and the reservation station/ROB. It maps architectural register numbers (x0–x31) to physical registers (p0–p63) through a register alias table (RAT). New destinations are allocated from a circular free list. Physical registers released at retirement go back onto the list. Output is registered one cycle later in the exact field set the reservation station dispatch ports consume.

## Interface
- ARCH_REGS, 32, architectural register count (5-bit index)
- PHYS_REGS, 64, physical register count (6-bit index)
- FREE_DEPTH, 32, free-list capacity (PHYS_REGS − ARCH_REGS)
- clk  in  1  rising-edge clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- in{1,2}_opcode  in  7  decoded opcode; 0 = no instruction in slot
- in{1,2}_rs1, in{1,2}_rs2, in{1,2}_rd  in  5 each  architectural register numbers
- in{1,2}_imm  in  32  immediate, passed through
- in{1,2}_funct7  in  7  passed through
- in{1,2}_funct3  in  3  passed through
- free_reg1, free_reg2  in  6 each  physical registers released by retire; 0 = none
- stall  out  1  combinational; 1 = current pair not accepted, decode must hold inputs
- instr{1,2}_opcode, _imm, _funct7, _funct3  out  registered passthrough (opcode 0 = bubble)
- instr{1,2}_p_rs1, _p_rs2, _p_rd, _p_old_rd  out  6 each  renamed operands

## Operation
- Writer: an opcode of rtype 7'b0110011, itype 7'b0010011 or lw 7'b0000011 with rd≠0. Only writers allocate a register.
- sw (7'b0100011), nonzero non-writers, and writers with rd=0 behave the same: p_rd=0, p_old_rd=0, no allocation. Their sources are still renamed.
- need = number of writer slots (0–2). stall = (need > count), where count is the free-list occupancy at the start of the cycle. Same-cycle returns are not counted.
- Accepted pair (stall=0), slot 1:
  - p_rs1 = RAT[rs1], p_rs2 = RAT[rs2].
  - If writer: p_rd = free-list head, p_old_rd = RAT[rd], RAT[rd] ← p_rd.
- Accepted pair, slot 2:
  - Same rules as slot 1, but sources and old_rd bypass slot 1.
  - If slot 1 is a writer and in2_rs1 / in2_rs2 / in2_rd equals in1_rd, the value used is slot 1's new p_rd (not the stale RAT entry).
  - If both slots write the same rd, the RAT ends at slot 2's p_rd.
  - Slot 2's allocation is the entry after the one slot 1 consumed. If only slot 2 writes, it takes the head.
- Stalled cycle: RAT and head are unchanged, and both output opcodes are registered as 0.
- Free list:
  - FIFO of FREE_DEPTH×6 with 5-bit head, 5-bit tail (wrapping 31→0) and 6-bit count.
  - Pops: need when accepted, else 0. Pushes: each nonzero free_reg, free_reg1 before free_reg2.
  - count_next = count − pops + pushes.
  - Push while count = FREE_DEPTH is illegal: the push is dropped and a simulation $error is raised.
- RAT[0] is permanently 0. p0 is never allocated and never pushed.
- Reset:
  - RAT[i] = i.
  - Free list holds p32..p63 in order: head=0, tail=0, count=32.
  - All registered outputs 0; stall=0 while inputs are empty.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Outputs stay stable for the whole cycle and update every cycle; there is no hold on the output side.
- The RAT/free-list update from edge N is visible to the pair at edge N+1, so back-to-back dependent pairs rename correctly with no bubble.
- A register returned at edge N becomes allocatable at edge N+1. It is not usable in the same cycle.
- stall depends only on the in*_opcode/in*_rd inputs and the count register, with no path from free_reg*.
- Reset mid-operation restores the full reset state immediately, asynchronously, regardless of pending stall or pushes.

## Test plan
- Reset, then slot 1 = add x5,x1,x2 and slot 2 empty → next cycle: p_rs1=1, p_rs2=2, p_rd=32, p_old_rd=5; instr2_opcode=0; count=31.
- Intra-pair RAW/WAW: slot 1 = addi x3,x3,4; slot 2 = add x3,x3,x3 → slot 1: p_rd=32, p_old_rd=3; slot 2: p_rs1=p_rs2=32, p_rd=33, p_old_rd=32; RAT[3]=33 afterwards.
- sw x7,0(x8) paired with add x0,x1,x1 → both p_rd=0, no allocation, count unchanged; sw p_rs2=RAT[7].
- Exhaustion: issue 16 writer pairs so count=0, then present one writer → stall=1, output opcode 0, RAT unchanged. Drive free_reg1=5 for one cycle → stall=0 the following cycle and the writer gets p_rd=5.
- Count=1 with two writers presented → stall=1 and nothing consumed, even if free_reg1/free_reg2 are nonzero in that cycle.
- Wrap-around: allocate all 32, return p40..p63 then p1..p8, and reallocate → allocation order 40..63,1..8; head/tail wrap with no lost or duplicated register.
